// File: rtl/hazard_ctrl.sv
// Decode-side interlock: destination scoreboard mirroring EX/MEM/WB, RAW stall
// generation, SIIC/RTI serialization and HALT latching for a forwarding-free pipe.
module hazard_ctrl #(
  parameter bit          RF_BYPASS  = 1'b1,
  parameter int unsigned SERIAL_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic [2:0] id_rs,
  input  logic       id_rs_used,
  input  logic [2:0] id_rt,
  input  logic       id_rt_used,
  input  logic       id_wr_en,
  input  logic [2:0] id_wr_sel,
  input  logic       mem_busy,
  output logic       stall_decode,
  output logic       stall_fetch,
  output logic       freeze,
  output logic       halted,
  output logic [2:0] sb_valid,
  output logic [8:0] sb_reg
);

  typedef enum logic [1:0] {
    S_RUN,
    S_SERIAL,
    S_HALTED
  } state_e;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_RTI   = 5'b00011;
  localparam logic [2:0] SER_INIT = 3'(SERIAL_CYC);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] sb_v_q, sb_v_d;
  logic [8:0] sb_r_q, sb_r_d;
  logic       raw;
  logic       stall;
  logic       issue;

  // Entry order in the packed vectors is {WB, MEM, EX}; WB is ignored when the RF bypasses.
  function automatic logic sb_match(input logic [2:0] v, input logic [8:0] regs,
                                    input logic [2:0] r);
    logic hit;
    hit = (v[0] && (regs[2:0] == r)) || (v[1] && (regs[5:3] == r));
    if (!RF_BYPASS)
      hit = hit || (v[2] && (regs[8:6] == r));
    return hit;
  endfunction

  always_comb begin
    raw = (id_rs_used && sb_match(sb_v_q, sb_r_q, id_rs)) ||
          (id_rt_used && sb_match(sb_v_q, sb_r_q, id_rt));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      S_RUN: begin
        stall = id_valid && raw;
        if (id_valid && !raw) begin
          if ((id_opcode == OP_SIIC) || (id_opcode == OP_RTI)) begin
            state_d = S_SERIAL;
            cnt_d   = SER_INIT;
          end else if (id_opcode == OP_HALT) begin
            state_d = S_HALTED;
          end
        end
      end
      S_SERIAL: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end
      end
      S_HALTED: stall = 1'b1;
      default: begin
        state_d = S_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign issue  = id_valid && !stall;
  assign sb_v_d = {sb_v_q[1:0], issue && id_wr_en};
  assign sb_r_d = {sb_r_q[5:0], id_wr_sel};

  // Everything holds while memory is busy; the pipe registers are frozen too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= 3'd0;
      sb_v_q  <= 3'd0;
      sb_r_q  <= 9'd0;
    end else if (!mem_busy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_v_q  <= sb_v_d;
      sb_r_q  <= sb_r_d;
    end
  end

  assign stall_decode = stall;
  assign stall_fetch  = stall;
  assign freeze       = mem_busy;
  assign halted       = (state_q == S_HALTED);
  assign sb_valid     = sb_v_q;
  assign sb_reg       = sb_r_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller that produces `stall_decode` for the ID/EX pipeline register, plus the matching fetch-hold and freeze controls. It keeps a 3-stage destination-register scoreboard that mirrors the EX/MEM/WB pipe registers and detects read-after-write hazards against instruction fields in decode. It also serializes SIIC/RTI and latches HALT. It sits beside the decode stage; the pipeline has no forwarding paths, so every RAW hazard is resolved by stalling.

## Interface
Parameters:
- `RF_BYPASS`, 1: register file forwards a same-cycle write to the read port; WB-stage entries never cause a hazard.
- `SERIAL_CYC`, 3: cycles that decode is held after SIIC/RTI issues (valid range 1–7).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset. Asynchronous and active-low.
- `id_valid` in 1: decode holds a real instruction.
- `id_opcode` in 5: decode instruction [15:11].
- `id_rs` in 3, `id_rs_used` in 1: source register 1 and its use flag.
- `id_rt` in 3, `id_rt_used` in 1: source register 2 and its use flag.
- `id_wr_en` in 1, `id_wr_sel` in 3: decode instruction writes register `id_wr_sel`.
- `mem_busy` in 1: data memory is multi-cycle busy; the whole pipe must freeze.
- `stall_decode` out 1: inject NOP into ID/EX (drives ID/EX `stall_decode`).
- `stall_fetch` out 1: hold PC and IF/ID.
- `freeze` out 1: hold all pipe registers (equals `mem_busy`).
- `halted` out 1: HALT has issued; the pipe is permanently quiesced.
- `sb_valid` out 3, `sb_reg` out 9: scoreboard {WB,MEM,EX} valid bits and register numbers (debug/verif).

## Operation
- Scoreboard: entries EX, MEM, WB, each holding {v, reg[2:0]}. On each non-frozen edge: WB←MEM, MEM←EX, EX←{issue & id_wr_en, id_wr_sel}.
  - issue = `id_valid` & ~`stall_decode`.
  - While `freeze`=1, all entries hold.
- Hazard: `raw` = (id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt)).
  - match(r) = (EX.v & EX.reg==r) | (MEM.v & MEM.reg==r) | (~RF_BYPASS & WB.v & WB.reg==r).
  - R0 is a normal register. There is no zero-register exemption.
- States:
  - RUN: `stall_decode` = `stall_fetch` = id_valid & raw.
    - Issuing opcode 00010 (SIIC) or 00011 (RTI) → SERIAL, count←SERIAL_CYC.
    - Issuing opcode 00000 (HALT) → HALTED.
  - SERIAL: `stall_decode`=`stall_fetch`=1. count decrements each non-frozen cycle; count==1 → RUN.
  - HALTED: `stall_decode`=`stall_fetch`=`halted`=1. Exit only by reset.
- Issue precedence: a stalled instruction (raw=1) does not issue, so it cannot trigger a state transition.
- `freeze`=`mem_busy` combinationally in every state.
  - State, count and scoreboard hold while frozen.
  - `stall_decode`/`stall_fetch` keep their computed values; the pipe registers ignore them while frozen.
- Bubbles drain naturally: a stalled RAW clears after at most 2 cycles (RF_BYPASS=1) or 3 cycles (RF_BYPASS=0) with no freeze.

## Timing
- Reset (rst=0, asynchronous): state RUN, count 0, all scoreboard entries invalid.
  - All outputs 0, except `freeze`, which follows `mem_busy`.
  - Reset asserted mid-SERIAL or in HALTED returns to RUN immediately.
- `stall_decode`, `stall_fetch` and `freeze` are combinational from state, scoreboard and decode inputs, valid in the same cycle.
- `halted` is registered: it asserts the cycle after HALT issues.
- Issue at edge N: EX entry valid after N, MEM after N+1, WB after N+2, cleared after N+3.
- SIIC issued at edge N: decode is stalled for cycles N+1 … N+SERIAL_CYC. The next instruction may issue at edge N+SERIAL_CYC+1.
- `mem_busy` held k cycles delays every count above by exactly k.

## Test plan
- RAW on EX (RF_BYPASS=1): ADD r3 issued, then decode `id_rs`=3 → `stall_decode`=1 for 2 cycles, issues on the 3rd; `sb_valid` walks 001→010→100.
- No hazard: back-to-back writers to r1,r2,r4 with readers of r5/r6 → `stall_decode` never asserts. Also check `id_rt`=3 with `id_rt_used`=0 does not stall.
- RF_BYPASS=0: same as the first scenario → stall lasts 3 cycles.
- SIIC with SERIAL_CYC=3 → stall asserted exactly 3 cycles, then RUN. Repeat with `mem_busy` high for 2 cycles mid-sequence → stall lasts 5 cycles.
- HALT issued → `halted`=1 the next cycle, stalls stay high for 20+ cycles. Drop `rst` low asynchronously mid-cycle → all outputs 0 and scoreboard cleared before the next edge.
- `mem_busy`=1 with EX.v=1 for r2 → `freeze`=1 and the scoreboard is unchanged for the full duration; decode reading r2 remains stalled until the freeze drops and the entry drains.
